// File: rtl/multi_voice_oscillator.sv
// -----------------------------------------------------------------------------
// multi_voice_oscillator
//
// Purpose:
//   N independent wavetable sample-index generators. Each voice divides the
//   clock by (rate+1) and steps a sample index through a table of programmable
//   width. The index walks the table in loop, one-shot or ping-pong order. It
//   feeds the wavetable RAM read port. The gate, rate and mode come from the
//   voice allocator.
//
// Ports:
//   clk_in            system clock
//   rst_in            asynchronous active-high reset
//   is_on_in          per-voice gate
//   wave_width_in     per-voice table length, voice v at [v*WW_WIDTH +: WW_WIDTH]
//   playback_rate_in  per-voice step period minus one, in clk cycles
//   mode_in           per-voice mode: 00 loop, 01 one-shot, 10 ping-pong,
//                     11 reserved (behaves as loop)
//   start_index_in    (OSC_START_OFFSET_EN only) index loaded on gate rise,
//                     clamped to the end of the table
//   sample_index_out  registered per-voice sample index
//   active_out        voice is stepping (gate high and not finished)
//   cycle_pulse_out   one-cycle pulse at each waveform boundary
//
// Configuration macro:
//   OSC_START_OFFSET_EN  adds start_index_in and the start-offset load
// -----------------------------------------------------------------------------
module multi_voice_oscillator #(
  parameter int NUM_VOICES = 4,
  parameter int WW_WIDTH   = 18,
  parameter int RATE_WIDTH = 24
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_VOICES-1:0]          is_on_in,
  input  logic [NUM_VOICES*WW_WIDTH-1:0] wave_width_in,
  input  logic [NUM_VOICES*RATE_WIDTH-1:0] playback_rate_in,
  input  logic [NUM_VOICES*2-1:0]        mode_in,
`ifdef OSC_START_OFFSET_EN
  input  logic [NUM_VOICES*WW_WIDTH-1:0] start_index_in,
`endif
  output logic [NUM_VOICES*WW_WIDTH-1:0] sample_index_out,
  output logic [NUM_VOICES-1:0]          active_out,
  output logic [NUM_VOICES-1:0]          cycle_pulse_out
);

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [RATE_WIDTH-1:0] r_cnt;
    logic [WW_WIDTH-1:0]   r_idx;
    logic                  r_down;
    logic                  r_done;
    logic                  r_active;
    logic                  r_pulse;

    logic [WW_WIDTH-1:0]   w_width;
    logic [WW_WIDTH-1:0]   w_end;
    logic [WW_WIDTH-1:0]   w_base;
    logic [WW_WIDTH-1:0]   w_idx_nxt;
    logic                  w_down_nxt;
    logic                  w_done_nxt;
    logic                  w_pulse_nxt;
    logic                  w_step;
    logic                  w_at_end;
    mode_e                 w_mode;

    assign w_width = wave_width_in[v*WW_WIDTH +: WW_WIDTH];
    // Widths 0 and 1 both collapse to a single-entry table.
    assign w_end   = (w_width == '0) ? '0 : w_width - 1'b1;
    assign w_mode  = mode_e'(mode_in[v*2 +: 2]);
    // Compare against the live rate so a rate cut mid-count steps at once.
    assign w_step  = (r_cnt >= playback_rate_in[v*RATE_WIDTH +: RATE_WIDTH]);

`ifdef OSC_START_OFFSET_EN
    logic                r_gate_d;
    logic [WW_WIDTH-1:0] w_start;
    assign w_start = start_index_in[v*WW_WIDTH +: WW_WIDTH];
    // On the first gated cycle the step logic starts from the clamped offset.
    assign w_base  = !r_gate_d ? ((w_start > w_end) ? w_end : w_start) : r_idx;
`else
    assign w_base  = r_idx;
`endif

    // ">=" rather than "==" so a table shortened mid-play is treated as ended.
    assign w_at_end = (w_base >= w_end);

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a signal unassigned and no latch is inferred.
      w_idx_nxt   = w_base;
      w_down_nxt  = (w_mode == MODE_PINGPONG) ? r_down : 1'b0;
      w_done_nxt  = 1'b0;
      w_pulse_nxt = 1'b0;
      if (w_step) begin
        case (w_mode)
          MODE_ONESHOT: begin
            if (w_at_end) begin
              w_idx_nxt   = w_end;
              w_done_nxt  = 1'b1;
              w_pulse_nxt = 1'b1;
            end else begin
              w_idx_nxt = w_base + 1'b1;
              if (w_base + 1'b1 == w_end) begin
                w_done_nxt  = 1'b1;
                w_pulse_nxt = 1'b1;
              end
            end
          end
          MODE_PINGPONG: begin
            if (w_end == '0) begin
              // A single-entry table has nowhere to travel: no motion, no pulse.
              w_idx_nxt  = '0;
              w_down_nxt = 1'b0;
            end else if (!r_down) begin
              if (w_at_end) begin
                w_down_nxt = 1'b1;
                w_idx_nxt  = (w_base > w_end) ? w_end : w_base - 1'b1;
              end else begin
                w_idx_nxt = w_base + 1'b1;
              end
            end else begin
              if (w_base == '0) begin
                w_down_nxt  = 1'b0;
                w_idx_nxt   = {{(WW_WIDTH-1){1'b0}}, 1'b1};
                w_pulse_nxt = 1'b1;
              end else if (w_base > w_end) begin
                w_idx_nxt = w_end;
              end else begin
                w_idx_nxt = w_base - 1'b1;
              end
            end
          end
          default: begin
            // Loop, and the reserved code that behaves as loop.
            if (w_at_end) begin
              w_idx_nxt   = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_idx_nxt = w_base + 1'b1;
            end
          end
        endcase
      end
    end

    // NOTE: reset is asynchronous. It clears every register without waiting
    // for a clock edge, so the RAM never sees a stale index during reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_cnt    <= '0;
        r_idx    <= '0;
        r_down   <= 1'b0;
        r_done   <= 1'b0;
        r_active <= 1'b0;
        r_pulse  <= 1'b0;
`ifdef OSC_START_OFFSET_EN
        r_gate_d <= 1'b0;
`endif
      end else if (!is_on_in[v]) begin
        r_cnt    <= '0;
        r_idx    <= '0;
        r_down   <= 1'b0;
        r_done   <= 1'b0;
        r_active <= 1'b0;
        r_pulse  <= 1'b0;
`ifdef OSC_START_OFFSET_EN
        r_gate_d <= 1'b0;
`endif
      end else begin
`ifdef OSC_START_OFFSET_EN
        r_gate_d <= 1'b1;
`endif
        if (r_done) begin
          // A finished one-shot freezes index and counter until the gate falls.
          r_active <= 1'b0;
          r_pulse  <= 1'b0;
        end else begin
          // NOTE: non-blocking assignments give every register the value computed
          // from the previous state, independent of statement order.
          r_cnt    <= w_step ? '0 : r_cnt + 1'b1;
          r_idx    <= w_idx_nxt;
          r_down   <= w_down_nxt;
          r_done   <= w_done_nxt;
          r_pulse  <= w_pulse_nxt;
          r_active <= !w_done_nxt;
        end
      end
    end

    assign sample_index_out[v*WW_WIDTH +: WW_WIDTH] = r_idx;
    assign active_out[v]      = r_active;
    assign cycle_pulse_out[v] = r_pulse;
  end

endmodule

// File: doc/multi_voice_oscillator.md
Name: multi_voice_oscillator

Overview:
- N-voice successor to the single-voice sample-index oscillator.
- Each voice owns a playback-rate counter and a sample index into a wavetable of programmable width.
- Per-voice playback modes: loop, one-shot, ping-pong. Per-voice status and cycle-boundary pulses.
- Sits between the voice allocator (gate, rate, mode) and the wavetable RAM read ports (index).

Parameters:
- NUM_VOICES, 4, number of independent voices.
- WW_WIDTH, 18, width of wave width and sample index.
- RATE_WIDTH, 24, width of playback rate and internal counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- is_on_in  input  NUM_VOICES  per-voice gate
- wave_width_in  input  NUM_VOICES*WW_WIDTH  per-voice table length in samples; voice v occupies bits [v*WW_WIDTH +: WW_WIDTH]
- playback_rate_in  input  NUM_VOICES*RATE_WIDTH  per-voice step period minus one, in clk cycles
- mode_in  input  NUM_VOICES*2  per-voice mode: 00 loop, 01 one-shot, 10 ping-pong, 11 reserved (behaves as loop)
- sample_index_out  output  NUM_VOICES*WW_WIDTH  registered per-voice sample index
- active_out  output  NUM_VOICES  voice is stepping (gate high and not finished)
- cycle_pulse_out  output  NUM_VOICES  one-cycle pulse at each waveform boundary

Behaviour:
- Reset (async, active-high): all counters 0, all indices 0, direction up, done cleared, active_out 0, cycle_pulse_out 0.
- Voices are fully independent; no shared state. All outputs are registered.
- Gate low: counter 0, index 0, direction up, done cleared, active_out 0, no pulse. Applies on the next clock edge, even mid-waveform.
- Gate high, not done: active_out 1.
  - If counter >= rate: step taken, counter set to 0.
  - Otherwise: counter increments.
  - Step period is rate+1 cycles; rate 0 steps every cycle.
  - Index first advances rate+1 cycles after the gate rises.
- Effective width W = max(wave_width, 1). End index E = W-1. Index >= E counts as at end, which covers a width reduced mid-play.
- Loop step:
  - At end: index goes to 0 and cycle_pulse fires on the same edge.
  - Otherwise: index+1.
- One-shot step:
  - Index+1 until it reaches E.
  - On the edge index becomes E (or on a step taken while already at end): done set, cycle_pulse fires, active_out 0 from that edge.
  - Index then holds at E and the counter holds until the gate falls.
- Ping-pong step:
  - Moving up: at end, reverse to down and index-1 (no pulse); otherwise index+1.
  - Moving down: at 0, reverse to up, index+1, cycle_pulse fires; otherwise index-1.
  - Period is 2*E steps. If index > E while moving up, index goes to E.
- W = 1: index stays 0 in every mode.
  - Loop: pulse on every step.
  - One-shot: done on first step.
  - Ping-pong: no steps move the index and no pulse fires.
- Mode change mid-play takes effect at the next step. Direction resets to up when the mode leaves ping-pong.
- Rate change mid-play: new compare value applies immediately to the running counter; counter >= new rate steps at once.
- cycle_pulse_out is high for exactly one cycle per boundary and never while the gate is low.

Optional Feature:
- Macro: OSC_START_OFFSET_EN.
- Defined:
  - Adds port start_index_in, input, NUM_VOICES*WW_WIDTH.
  - On the cycle the gate is first seen high (gate rising), index loads min(start_index, E) instead of 0.
  - Loop and one-shot wrap/restart still go to 0.
- Undefined: port absent; gate rise starts at index 0.

Test Plan:
- Loop, W=4, rate=2, gate held high on voice 0 -> index 0,1,2,3,0 changing every 3 cycles; cycle_pulse on the 3->0 edge only; other voices stay 0.
- One-shot, W=3, rate=0 -> index 0,1,2 then holds at 2; pulse and active_out fall on the edge index becomes 2; gate low then high restarts at 0.
- Ping-pong, W=4, rate=0 -> index 0,1,2,3,2,1,0,1; pulse only on the 0->1 edge after the descent.
- Loop, W=8, index at 5 when wave_width is cut to 4 -> next step index 0 with pulse; gate dropped mid-wave -> index 0, active_out 0 next edge.
- Async reset asserted mid-count between clock edges -> all outputs 0 immediately, without waiting for a clock edge; W=0 or W=1 on a voice -> index stays 0.
- With OSC_START_OFFSET_EN, start_index=6, W=4 -> first index 3; after wrap, index 0.
